// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - UART-fed multi-target boot loader with checksum, timeout and write back-pressure
//
// Purpose: parses a framed byte stream into word writes to NUM_TGT memories and
// holds the core in reset until an END frame is accepted after an error-free frame.
//
// Frame:     A5 | TGT | ADDR lo,hi | LEN lo,hi (words) | BPW*LEN data bytes, LSB first | CSUM
// END frame: A5 FF
//
// Ports:
//   clk_i        in   1        clock
//   rst_i        in   1        synchronous reset, active-high
//   rx_dv_i      in   1        one-cycle strobe, rx_byte_i valid
//   rx_byte_i    in   8        received byte
//   mem_we_o     out  NUM_TGT  one-hot write request, held until granted
//   mem_gnt_i    in   1        grant for the asserted request
//   mem_addr_o   out  AW       word address
//   mem_wdata_o  out  DW       write data
//   sys_rst_o    out  1        core reset request, active-high
//   done_o       out  1        END accepted, program loaded
//   err_o        out  4        sticky: [0] bad target [1] checksum [2] timeout [3] overrun
module boot_loader_ctrl #(
    parameter int AW      = 14,
    parameter int DW      = 32,
    parameter int NUM_TGT = 2,
    parameter int TIMEOUT = 100000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_dv_i,
    input  logic [7:0]         rx_byte_i,
    output logic [NUM_TGT-1:0] mem_we_o,
    input  logic               mem_gnt_i,
    output logic [AW-1:0]      mem_addr_o,
    output logic [DW-1:0]      mem_wdata_o,
    output logic               sys_rst_o,
    output logic               done_o,
    output logic [3:0]         err_o
);

    localparam int BPW = DW / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam int TMW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TGT,
        S_ADDR0,
        S_ADDR1,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [TW-1:0]      r_tgt;
    logic [7:0]         r_lo;          // low byte of ADDR or LEN while waiting for the high byte
    logic [AW-1:0]      r_next_addr;   // address the next accepted word will be written to
    logic [15:0]        r_len;
    logic [15:0]        r_words;       // words assembled so far in this frame
    logic [BCW-1:0]     r_byte_cnt;
    logic [DW-1:0]      r_asm;
    logic [7:0]         r_sum;
    logic [TMW-1:0]     r_timer;
    logic [3:0]         r_err;
    logic               r_err_prev;    // errors from before this frame's A5 cleared r_err
    logic               r_done;
    logic               r_sys_rst;

    logic [NUM_TGT-1:0] r_we;
    logic [AW-1:0]      r_wr_addr;
    logic [DW-1:0]      r_wdata;

    logic               w_last_byte;
    logic               w_word_done;
    logic               w_busy;
    logic               w_word_load;
    logic [DW-1:0]      w_word;
    logic [7:0]         w_sum_next;
    logic               w_tgt_ok;

    // A held request that is not being granted this cycle blocks a new word.
    // A grant in the same cycle frees the holding register so the next word loads gap-free.
    assign w_last_byte = (r_byte_cnt == BCW'(BPW - 1));
    assign w_word_done = (r_state == S_DATA) && rx_dv_i && w_last_byte;
    assign w_busy      = (r_we != '0) && !mem_gnt_i;
    assign w_word_load = w_word_done && !w_busy;
    // Bytes arrive LSB first: each new byte enters at the top and slides down.
    assign w_word      = (r_asm >> 8) | (DW'(rx_byte_i) << (DW - 8));
    assign w_sum_next  = r_sum + rx_byte_i;
    assign w_tgt_ok    = (int'(rx_byte_i) < NUM_TGT);

    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_wr_addr;
    assign mem_wdata_o = r_wdata;
    assign sys_rst_o   = r_sys_rst;
    assign done_o      = r_done;
    assign err_o       = r_err;

    // Write holding register, independent of the parser so a pending write
    // still completes after a timeout, checksum error or END.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we      <= '0;
            r_wr_addr <= '0;
            r_wdata   <= '0;
        end else if (w_word_load) begin
            r_we      <= NUM_TGT'(1) << r_tgt;
            r_wr_addr <= r_next_addr;
            r_wdata   <= w_word;
        end else if (r_we != '0 && mem_gnt_i) begin
            r_we      <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_tgt       <= '0;
            r_lo        <= '0;
            r_next_addr <= '0;
            r_len       <= '0;
            r_words     <= '0;
            r_byte_cnt  <= '0;
            r_asm       <= '0;
            r_sum       <= '0;
            r_timer     <= '0;
            r_err       <= '0;
            r_err_prev  <= 1'b0;
            r_done      <= 1'b0;
            r_sys_rst   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (rx_dv_i && rx_byte_i == 8'hA5) begin
                        r_state    <= S_TGT;
                        r_err      <= '0;
                        r_err_prev <= (r_err != '0);
                        r_sum      <= '0;
                        r_words    <= '0;
                        r_byte_cnt <= '0;
                    end
                end

                S_DONE: begin
                    r_done    <= 1'b1;
                    r_sys_rst <= 1'b0;
                end

                default: begin
                    if (!rx_dv_i) begin
                        if (r_timer == TMW'(TIMEOUT - 1)) begin
                            r_err[2] <= 1'b1;
                            r_state  <= S_IDLE;
                            r_timer  <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end else begin
                        r_timer <= '0;
                        r_sum   <= w_sum_next;
                        case (r_state)
                            S_TGT: begin
                                if (w_tgt_ok) begin
                                    r_tgt   <= TW'(rx_byte_i);
                                    r_state <= S_ADDR0;
                                end else if (rx_byte_i == 8'hFF) begin
                                    if (!r_err_prev) begin
                                        r_state   <= S_DONE;
                                        r_done    <= 1'b1;
                                        r_sys_rst <= 1'b0;
                                    end else begin
                                        r_state <= S_IDLE;
                                    end
                                end else begin
                                    r_err[0] <= 1'b1;
                                    r_state  <= S_IDLE;
                                end
                            end
                            S_ADDR0: begin
                                r_lo    <= rx_byte_i;
                                r_state <= S_ADDR1;
                            end
                            S_ADDR1: begin
                                r_next_addr <= AW'({rx_byte_i, r_lo});
                                r_state     <= S_LEN0;
                            end
                            S_LEN0: begin
                                r_lo    <= rx_byte_i;
                                r_state <= S_LEN1;
                            end
                            S_LEN1: begin
                                r_len   <= {rx_byte_i, r_lo};
                                r_state <= ({rx_byte_i, r_lo} == 16'd0) ? S_CSUM : S_DATA;
                            end
                            S_DATA: begin
                                r_asm <= w_word;
                                if (w_last_byte) begin
                                    r_byte_cnt <= '0;
                                    // A dropped word does not consume an address.
                                    if (w_busy) begin
                                        r_err[3] <= 1'b1;
                                    end else begin
                                        r_next_addr <= r_next_addr + 1'b1;
                                    end
                                    if (r_words == r_len - 16'd1) begin
                                        r_state <= S_CSUM;
                                    end
                                    r_words <= r_words + 16'd1;
                                end else begin
                                    r_byte_cnt <= r_byte_cnt + 1'b1;
                                end
                            end
                            S_CSUM: begin
                                if (w_sum_next != 8'h00) begin
                                    r_err[1] <= 1'b1;
                                end
                                r_state <= S_IDLE;
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - scoreboard bench for boot_loader_ctrl
module tb_boot_loader_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int NT = 2;
    localparam int TO = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          rx_dv_i;
    logic [7:0]    rx_byte_i;
    logic [NT-1:0] mem_we_o;
    logic          mem_gnt_i;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          sys_rst_o;
    logic          done_o;
    logic [3:0]    err_o;

    boot_loader_ctrl #(.AW(AW), .DW(DW), .NUM_TGT(NT), .TIMEOUT(TO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_dv_i     (rx_dv_i),
        .rx_byte_i   (rx_byte_i),
        .mem_we_o    (mem_we_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .sys_rst_o   (sys_rst_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [NT-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    wr_t        prev_val;
    logic       prev_held = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         gnt_mode = 0;   // 0: grant always, 1: grant never, 2: random but bounded stall
    int         held_cnt = 0;
    logic [7:0] fd[0:63];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_dv_i   = 1'b1;
        rx_byte_i = b;
        tick(1);
        rx_dv_i   = 1'b0;
        tick(gap);
    endtask

    // Sends one frame built from fd[], pushing the first nexp words onto the scoreboard.
    task automatic send_frame(input logic [7:0] tgt, input logic [15:0] addr, input int len,
                              input bit bad_csum, input int maxgap, input int nexp);
        logic [7:0]  sum;
        logic [15:0] a16;
        wr_t         e;
        for (int w = 0; w < nexp; w++) begin
            a16    = addr + 16'(w);
            e.we   = NT'(1) << tgt;
            e.addr = a16[AW-1:0];
            e.data = {fd[4*w+3], fd[4*w+2], fd[4*w+1], fd[4*w]};
            exp_q.push_back(e);
        end
        send(8'hA5, $urandom_range(0, maxgap));
        send(tgt, $urandom_range(0, maxgap));
        if (int'(tgt) >= NT) return;
        sum = tgt + addr[7:0] + addr[15:8] + 8'(len) + 8'(len >> 8);
        send(addr[7:0], $urandom_range(0, maxgap));
        send(addr[15:8], $urandom_range(0, maxgap));
        send(8'(len), $urandom_range(0, maxgap));
        send(8'(len >> 8), $urandom_range(0, maxgap));
        for (int i = 0; i < 4 * len; i++) begin
            sum = sum + fd[i];
            send(fd[i], $urandom_range(0, maxgap));
        end
        send((8'h00 - sum) ^ (bad_csum ? 8'h01 : 8'h00), 0);
    endtask

    task automatic chk_err(input string name, input logic [3:0] exp);
        tick(4);
        check(name, err_o, exp);
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_we_o != '0) held_cnt++;
            else held_cnt = 0;
            case (gnt_mode)
                0:       mem_gnt_i = 1'b1;
                1:       mem_gnt_i = 1'b0;
                default: mem_gnt_i = (held_cnt >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a write completes at the next edge when request and grant are both high.
    always @(negedge clk_i) begin
        if (mem_we_o != '0 && mem_gnt_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got we=%0h addr=%0h data=%0h expected none",
                         mem_we_o, mem_addr_o, mem_wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_we", mem_we_o, mon_e.we);
                check("wr_addr", mem_addr_o, mon_e.addr);
                check("wr_data", mem_wdata_o, mon_e.data);
            end
        end
        if (prev_held && mem_we_o != '0)
            check("held_stable", {mem_we_o, mem_addr_o, mem_wdata_o}, prev_val);
        prev_held = (mem_we_o != '0) && (mem_gnt_i !== 1'b1);
        prev_val  = {mem_we_o, mem_addr_o, mem_wdata_o};
    end

    initial begin
        logic [7:0]  tgt;
        logic [15:0] addr;
        logic [3:0]  eerr;
        int          len;
        int          r;
        bit          bad;
        int          k;

        rst_i     = 1'b1;
        rx_dv_i   = 1'b0;
        rx_byte_i = 8'h00;
        mem_gnt_i = 1'b1;
        tick(3);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_sys_rst", sys_rst_o, 1);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        rst_i = 1'b0;
        tick(2);

        // Idle noise, then a clean frame
        send(8'h3C, 0);
        send(8'h00, 1);
        for (int i = 0; i < 8; i++) fd[i] = 8'h11 + 8'(i);
        send_frame(8'h00, 16'h0010, 2, 1'b0, 0, 2);
        chk_err("t1_err", 4'b0000);

        // Bad checksum, writes still issued, END refused
        send_frame(8'h00, 16'h0010, 2, 1'b1, 0, 2);
        chk_err("t2_err", 4'b0010);
        send(8'hA5, 0);
        send(8'hFF, 0);
        tick(2);
        check("t2_no_done", done_o, 0);
        check("t2_sys_rst", sys_rst_o, 1);

        // Bad target, then timeout, then a clean frame shows the parser is back in IDLE
        send_frame(8'h05, 16'h0000, 0, 1'b0, 0, 0);
        chk_err("t4_badtgt", 4'b0001);
        send(8'hA5, 0);
        send(8'h00, 0);
        tick(TO + 10);
        check("t4_timeout", err_o, 4'b0100);
        for (int i = 0; i < 4; i++) fd[i] = 8'($urandom);
        send_frame(8'h01, 16'h1234, 1, 1'b0, 2, 1);
        chk_err("t4_after_timeout", 4'b0000);

        // Overrun: grant withheld over two word completions
        gnt_mode = 1;
        tick(1);
        for (int i = 0; i < 8; i++) fd[i] = 8'($urandom);
        send_frame(8'h01, 16'h0020, 2, 1'b0, 0, 1);
        chk_err("t5_overrun", 4'b1000);
        check("t5_we_held", mem_we_o, 2'b10);
        check("t5_addr_held", mem_addr_o, 14'h0020);
        check("t5_data_held", mem_wdata_o, {fd[3], fd[2], fd[1], fd[0]});
        gnt_mode = 0;
        tick(3);
        check("t5_one_write", exp_q.size(), 0);

        // Address wrap
        for (int i = 0; i < 8; i++) fd[i] = 8'($urandom);
        send_frame(8'h01, 16'h3FFF, 2, 1'b0, 1, 2);
        chk_err("t6_wrap_err", 4'b0000);

        // Randomised frames with bounded grant stalls
        gnt_mode = 2;
        for (int f = 0; f < 40; f++) begin
            r    = $urandom_range(0, 9);
            tgt  = (r < 8) ? 8'(r % 2) : ((r == 8) ? 8'h02 : 8'h7E);
            addr = 16'($urandom);
            len  = $urandom_range(0, 4);
            bad  = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4 * len; i++) fd[i] = 8'($urandom);
            if (int'(tgt) >= NT) eerr = 4'b0001;
            else if (bad)        eerr = 4'b0010;
            else                 eerr = 4'b0000;
            send_frame(tgt, addr, len, bad, 3, (int'(tgt) < NT) ? len : 0);
            chk_err("rand_err", eerr);
        end
        gnt_mode = 0;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        check("rand_drain", exp_q.size(), 0);

        // Reset mid-DATA drops the pending write
        gnt_mode = 1;
        tick(1);
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h04, 0);
        send(8'h00, 0);
        for (int i = 1; i <= 5; i++) send(8'(i), 0);
        tick(2);
        check("rst_mid_pending", mem_we_o, 2'b01);
        rst_i = 1'b1;
        tick(1);
        check("rst_mid_we", mem_we_o, 0);
        check("rst_mid_sys_rst", sys_rst_o, 1);
        check("rst_mid_err", err_o, 0);
        rst_i    = 1'b0;
        gnt_mode = 0;
        tick(2);

        // Clean frame then END
        for (int i = 0; i < 4; i++) fd[i] = 8'($urandom);
        send_frame(8'h00, 16'h0040, 1, 1'b0, 1, 1);
        chk_err("t3_err", 4'b0000);
        send(8'hA5, 0);
        rx_dv_i   = 1'b1;
        rx_byte_i = 8'hFF;
        check("t3_done_before", done_o, 0);
        tick(1);
        rx_dv_i = 1'b0;
        check("t3_done", done_o, 1);
        check("t3_sys_rst", sys_rst_o, 0);
        send_frame(8'h00, 16'h0050, 1, 1'b0, 0, 0);
        tick(3);
        check("t3_done_stays", done_o, 1);
        check("t3_err_stays", err_o, 0);

        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        check("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
